// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider: special cases resolve in 1 cycle, normal path in 1+RECIP_CYCLES+MUL_CYCLES.
// Accepts one operation at a time in IDLE; the result is held in DONE until out_rdy_i.

// Reciprocal of a normal operand, truncated; the long divide is timed as a multicycle path.
module fp_div_recip (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  logic [24:0] q;
  logic        unused_q_bit;

  // 2^47 / m lands in (2^23, 2^24]; bit 24 only for an exact power of two
  assign q = 25'({2'b01, 47'h0} / {25'h0, 1'b1, x_i[22:0]});
  assign unused_q_bit = q[23];
  assign y_o = q[24] ? {x_i[31], 8'd254 - x_i[30:23], 23'h0}
                     : {x_i[31], 8'd253 - x_i[30:23], q[22:0]};
endmodule

// Truncating multiply of two normal operands; no range or special handling.
module fp_div_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic [47:0] prod;
  logic [9:0]  e_sum;
  logic        unused_bits;

  assign prod  = {24'h0, 1'b1, a_i[22:0]} * {24'h0, 1'b1, b_i[22:0]};
  assign e_sum = {2'b0, a_i[30:23]} + {2'b0, b_i[30:23]} - 10'd127;
  assign unused_bits = ^{prod[22:0], e_sum[9:8]};
  assign p_o = prod[47] ? {a_i[31] ^ b_i[31], 8'(e_sum + 10'd1), prod[46:24]}
                        : {a_i[31] ^ b_i[31], e_sum[7:0], prod[45:23]};
endmodule

module fp_div_seq #(
  parameter int unsigned RECIP_CYCLES = 3,
  parameter int unsigned MUL_CYCLES   = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_vld_i,
  output logic        in_rdy_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        out_vld_o,
  input  logic        out_rdy_i,
  output logic [31:0] result_o,
  output logic        div_by_zero_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        underflow_o
);
  localparam int unsigned CNT_MAX = (RECIP_CYCLES > MUL_CYCLES) ? RECIP_CYCLES : MUL_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, RECIP, MUL, DONE} state_t;
  typedef struct packed {
    logic dz;
    logic inv;
    logic ovf;
    logic unf;
  } flags_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d, recip_q, recip_d, res_q, res_d;
  flags_t        flags_q, flags_d;
  logic          rdy_en_q;

  logic [31:0]   recip_w, prod_w;
  logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
  logic          special;
  logic [31:0]   spec_res;
  flags_t        spec_flags;
  logic signed [9:0] e_res;
  logic          sign_q;

  fp_div_recip u_recip (.x_i({1'b0, 8'd127, b_q[22:0]}), .y_o(recip_w));
  fp_div_mul   u_mul   (.a_i({1'b0, 8'd127, a_q[22:0]}), .b_i(recip_q), .p_o(prod_w));

  // Denormals (exp == 0) classify as zero
  assign a_zero  = (a_i[30:23] == 8'h00);
  assign b_zero  = (b_i[30:23] == 8'h00);
  assign a_nan   = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'h0);
  assign b_nan   = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'h0);
  assign a_inf   = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'h0);
  assign b_inf   = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'h0);
  assign sign_in = a_i[31] ^ b_i[31];
  assign sign_q  = a_q[31] ^ b_q[31];

  always_comb begin
    special    = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res       = 32'h7FC00000;
      spec_flags.inv = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res      = {sign_in, 8'hFF, 23'h0};
      spec_flags.dz = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 23'h0};
    end else if (b_inf || a_zero) begin
      spec_res = {sign_in, 31'h0};
    end else begin
      special = 1'b0;
    end
  end

  assign e_res = signed'({2'b0, prod_w[30:23]} + {2'b0, a_q[30:23]} - {2'b0, b_q[30:23]});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    recip_d = recip_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_vld_i && rdy_en_q) begin
          a_d     = a_i;
          b_d     = b_i;
          flags_d = '0;
          if (special) begin
            res_d   = spec_res;
            flags_d = spec_flags;
            state_d = DONE;
          end else begin
            cnt_d   = CW'(RECIP_CYCLES - 1);
            state_d = RECIP;
          end
        end
      end
      RECIP: begin
        if (cnt_q == '0) begin
          recip_d = recip_w;
          cnt_d   = CW'(MUL_CYCLES - 1);
          state_d = MUL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          if (e_res >= 10'sd255) begin
            res_d       = {sign_q, 8'hFF, 23'h0};
            flags_d.ovf = 1'b1;
          end else if (e_res <= 10'sd0) begin
            res_d       = {sign_q, 31'h0};
            flags_d.unf = 1'b1;
          end else begin
            res_d = {sign_q, e_res[7:0], prod_w[22:0]};
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      recip_q  <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      recip_q  <= recip_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign in_rdy_o      = rdy_en_q && (state_q == IDLE);
  assign out_vld_o     = (state_q == DONE);
  assign result_o      = res_q;
  assign div_by_zero_o = flags_q.dz;
  assign invalid_o     = flags_q.inv;
  assign overflow_o    = flags_q.ovf;
  assign underflow_o   = flags_q.unf;
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expected quotient, flags and latency queued at accept, checked at output.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] res;
  logic        dz, inv, ovf, unf;
  logic [3:0]  flags_w;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  f;
    int          tol;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  assign flags_w = {dz, inv, ovf, unf};

  fp_div_seq #(.RECIP_CYCLES(3), .MUL_CYCLES(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy),
    .a_i(a_in), .b_i(b_in),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy),
    .result_o(res),
    .div_by_zero_o(dz), .invalid_o(inv), .overflow_o(ovf), .underflow_o(unf)
  );

  // tol is in ulps, measured as the distance between bit patterns
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int tol = 0);
    longint d;
    total++;
    d = longint'(obs) - longint'(expv);
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      bad++;
      $display("FAIL %s: got %h want %h (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic [3:0] f, input int tol, input int lat,
                        input int hold, input bit noise);
    exp_t e;
    int n;
    logic [31:0] held_q;
    logic [3:0]  held_f;
    @(negedge clk);
    n = 0;
    while (!in_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_rdy", 32'(in_rdy), 32'd1);
    in_vld = 1'b1;
    a_in = a;
    b_in = b;
    e.q = q; e.f = f; e.tol = tol; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    in_vld = 1'b0;
    if (noise) begin
      in_vld = 1'b1;
      a_in = 32'h3F800000;
      b_in = 32'h3F800000;
    end
    n = 1;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_vld = 1'b0;
    e = sb.pop_front();
    chk("latency", 32'(n), 32'(e.lat));
    if (out_vld) begin
      chk("quotient", res, e.q, e.tol);
      chk("flags", 32'(flags_w), 32'(e.f));
      held_q = res;
      held_f = flags_w;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_vld", 32'(out_vld), 32'd1);
        chk("hold_q", res, held_q);
        chk("hold_flags", 32'(flags_w), 32'(held_f));
        chk("hold_rdy", 32'(in_rdy), 32'd0);
      end
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      chk("release_vld", 32'(out_vld), 32'd0);
      chk("release_rdy", 32'(in_rdy), 32'd1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'd0);
    chk("rst_q", res, 32'h0);
    chk("rst_flags", 32'(flags_w), 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_rdy_before_edge", 32'(in_rdy), 32'd0);
    @(negedge clk);
    chk("rel_rdy_after_edge", 32'(in_rdy), 32'd1);

    // abort 6/3 while in RECIP
    in_vld = 1'b1;
    a_in = 32'h40C00000;
    b_in = 32'h40400000;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 32'(out_vld), 32'd0);
    chk("abort_rdy", 32'(in_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_rdy", 32'(in_rdy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_out", 32'(out_vld), 32'd0);
    end

    //      A             B             quotient      flags  tol lat hold noise
    run_op(32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 2, 5, 0, 1'b0);
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 2, 5, 4, 1'b0);
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000, 0, 1, 0, 1'b0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0100, 0, 1, 0, 1'b0);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0100, 0, 1, 0, 1'b0);
    run_op(32'h40A00000, 32'hFF800000, 32'h80000000, 4'b0000, 0, 1, 0, 1'b0);
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 0, 5, 0, 1'b0);
    run_op(32'h00800000, 32'h40800000, 32'h00000000, 4'b0001, 0, 5, 0, 1'b0);
    run_op(32'h00800000, 32'h00800000, 32'h3F800000, 4'b0000, 2, 5, 0, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 2, 5, 0, 1'b0);
    run_op(32'h41200000, 32'h40800000, 32'h40200000, 4'b0000, 2, 5, 2, 1'b1);
    run_op(32'hC0E00000, 32'h40000000, 32'hC0600000, 4'b0000, 2, 5, 0, 1'b0);
    run_op(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0100, 0, 1, 0, 1'b0);
    run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0, 1, 0, 1'b0);
    run_op(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 0, 1, 0, 1'b0);
    run_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0, 1, 0, 1'b0);
    run_op(32'h3F800000, 32'h00000001, 32'h7F800000, 4'b1000, 0, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
